// File: rtl/mips_trace_buffer.sv
// Commit-trace capture buffer: circular store of retired-instruction records with
// masked-PC trigger, post-trigger capture and an oldest-first valid/ready readout.
module mips_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int DATA_W    = 32,
  parameter int POST_TRIG = 8,
  parameter int WRAP      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic [DATA_W-1:0]        trig_mask,
  input  logic                     commit_valid,
  input  logic [DATA_W-1:0]        pc,
  input  logic [DATA_W-1:0]        instruction,
  input  logic                     reg_write_en,
  input  logic [4:0]               write_to_register,
  input  logic [DATA_W-1:0]        data_result,
  input  logic                     mem_write_en,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instruction,
  output logic [DATA_W-1:0]        rd_data,
  output logic [4:0]               rd_reg,
  output logic [1:0]               rd_flags,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     triggered,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PT   = AW'(POST_TRIG);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
  logic [AW:0]     count_q, count_d;
  logic            trig_q, trig_d, ovf_q, ovf_d;
  logic            we, hit, full;

  logic [DATA_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_ins  [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [4:0]        mem_reg  [DEPTH];
  logic [1:0]        mem_flg  [DEPTH];

  assign hit  = commit_valid && (((pc ^ trig_pc) & trig_mask) == '0);
  assign full = (count_q == FULL);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    post_d   = post_q;
    count_d  = count_q;
    trig_d   = trig_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d  = ARMED;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          post_d   = '0;
          count_d  = '0;
          trig_d   = 1'b0;
          ovf_d    = 1'b0;
        end else if (state_q == DONE && rd_valid && rd_ready) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          count_d  = count_q - (AW+1)'(1);
        end
      end
      default: begin // ARMED / POST: capture
        if (commit_valid) begin
          if (!full) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + (AW+1)'(1);
          end else begin
            ovf_d = 1'b1;
            if (WRAP != 0) begin
              we       = 1'b1;
              wr_ptr_d = wr_ptr_q + AW'(1);
              rd_ptr_d = rd_ptr_q + AW'(1);
            end
          end
          if (state_q == ARMED && hit) begin
            trig_d  = 1'b1;
            post_d  = PT;
            state_d = (POST_TRIG == 0) ? DONE : POST;
          end else if (state_q == POST) begin
            post_d = post_q - AW'(1);
            if (post_q == AW'(1)) state_d = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      post_q   <= '0;
      count_q  <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      post_q   <= post_d;
      count_q  <= count_d;
      trig_q   <= trig_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately left unreset; count/pointers define what is live.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_pc[wr_ptr_q]   <= pc;
      mem_ins[wr_ptr_q]  <= instruction;
      mem_data[wr_ptr_q] <= data_result;
      mem_reg[wr_ptr_q]  <= write_to_register;
      mem_flg[wr_ptr_q]  <= {mem_write_en, reg_write_en};
    end
  end

  assign rd_valid       = (state_q == DONE) && (count_q != '0);
  assign rd_pc          = rd_valid ? mem_pc[rd_ptr_q]   : '0;
  assign rd_instruction = rd_valid ? mem_ins[rd_ptr_q]  : '0;
  assign rd_data        = rd_valid ? mem_data[rd_ptr_q] : '0;
  assign rd_reg         = rd_valid ? mem_reg[rd_ptr_q]  : '0;
  assign rd_flags       = rd_valid ? mem_flg[rd_ptr_q]  : '0;
  assign state          = state_q;
  assign count          = count_q;
  assign triggered      = trig_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench: four buffer configurations share commit/readout inputs, each with its own arm.
module tb_mips_trace_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  arm_v = '0;
  logic [31:0] trig_pc = '0, trig_mask = '1;
  logic        commit_valid = 1'b0, reg_write_en = 1'b0, mem_write_en = 1'b0, rd_ready = 1'b0;
  logic [31:0] pc = '0, instruction = '0, data_result = '0;
  logic [4:0]  write_to_register = '0;

  logic        rd_valid_w [4];
  logic [31:0] rd_pc_w [4], rd_ins_w [4], rd_data_w [4];
  logic [4:0]  rd_reg_w [4];
  logic [1:0]  rd_flags_w [4], state_w [4];
  logic [4:0]  count_w [4];
  logic        trig_w [4], ovf_w [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // g0: 16/POST 2/wrap, g1: 4/POST 1/wrap, g2: 4/POST 2/no wrap, g3: 16/POST 0/wrap
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 1 || g == 2) ? 4 : 16;
    localparam int P = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int W = (g == 2) ? 0 : 1;
    logic [$clog2(D):0] cnt;
    mips_trace_buffer #(.DEPTH(D), .DATA_W(32), .POST_TRIG(P), .WRAP(W)) u_dut (
      .clk(clk), .reset(reset), .arm(arm_v[g]), .trig_pc(trig_pc), .trig_mask(trig_mask),
      .commit_valid(commit_valid), .pc(pc), .instruction(instruction),
      .reg_write_en(reg_write_en), .write_to_register(write_to_register),
      .data_result(data_result), .mem_write_en(mem_write_en),
      .rd_valid(rd_valid_w[g]), .rd_ready(rd_ready), .rd_pc(rd_pc_w[g]),
      .rd_instruction(rd_ins_w[g]), .rd_data(rd_data_w[g]), .rd_reg(rd_reg_w[g]),
      .rd_flags(rd_flags_w[g]), .state(state_w[g]), .count(cnt),
      .triggered(trig_w[g]), .overflow(ovf_w[g]));
    assign count_w[g] = 5'(cnt);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one commit at the falling edge; the record is sampled at the next rising edge.
  task automatic commit(logic [31:0] a, logic v);
    @(negedge clk);
    commit_valid = v; pc = a; instruction = 32'hABC0_0000 | a; data_result = ~a;
    write_to_register = a[6:2]; reg_write_en = 1'b1; mem_write_en = a[2];
  endtask

  task automatic idle();
    @(negedge clk);
    commit_valid = 1'b0;
  endtask

  task automatic do_arm(int k);
    @(negedge clk);
    arm_v[k] = 1'b1;
    @(negedge clk);
    arm_v[k] = 1'b0;
  endtask

  task automatic status(string tag, int k, logic [1:0] st, logic [4:0] cnt, logic tr, logic ov);
    chk({tag, "_state"}, 32'(state_w[k]), 32'(st));
    chk({tag, "_count"}, 32'(count_w[k]), 32'(cnt));
    chk({tag, "_trig"},  32'(trig_w[k]),  32'(tr));
    chk({tag, "_ovf"},   32'(ovf_w[k]),   32'(ov));
  endtask

  // Drain with rd_ready held high, expecting pcs base, base+4, ...
  task automatic drain(string tag, int k, logic [31:0] base, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_vld"}, 32'(rd_valid_w[k]), 32'd1);
      chk({tag, "_pc"}, rd_pc_w[k], base + 32'(4 * i));
      rd_ready = 1'b1;
    end
    @(negedge clk);
    rd_ready = 1'b0;
    chk({tag, "_empty_vld"}, 32'(rd_valid_w[k]), 32'd0);
    chk({tag, "_empty_pc"}, rd_pc_w[k], 32'd0);
    chk({tag, "_empty_cnt"}, 32'(count_w[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] exp5 [4];
    int idx;
    logic r;

    // reset state
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    status("rst", 0, 2'd0, 5'd0, 1'b0, 1'b0);
    chk("rst_vld", 32'(rd_valid_w[0]), 32'd0);
    chk("rst_pc", rd_pc_w[0], 32'd0);

    // 1: basic capture; commit during the arm cycle must not be stored
    trig_pc = 32'h10; trig_mask = 32'hFFFF_FFFF;
    commit(32'h99C, 1'b1);
    arm_v[0] = 1'b1;
    @(negedge clk); arm_v[0] = 1'b0; commit_valid = 1'b0;
    status("t1_arm", 0, 2'd1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      commit(32'(4 * i), 1'b1);
      if (i == 5) begin
        chk("t1_post_state", 32'(state_w[0]), 32'd2);
        chk("t1_post_trig", 32'(trig_w[0]), 32'd1);
      end
    end
    idle();
    status("t1_done", 0, 2'd3, 5'd7, 1'b1, 1'b0);
    chk("t1_ins", rd_ins_w[0], 32'hABC0_0000);
    @(negedge clk); rd_ready = 1'b1;
    @(negedge clk); rd_ready = 1'b0;
    chk("t1_pc1", rd_pc_w[0], 32'h4);
    chk("t1_data1", rd_data_w[0], 32'hFFFF_FFFB);
    chk("t1_reg1", 32'(rd_reg_w[0]), 32'd1);
    chk("t1_flags1", 32'(rd_flags_w[0]), 32'd3);
    drain("t1_rd", 0, 32'h4, 6);

    // 2: wrap with DEPTH 4
    trig_pc = 32'h20;
    do_arm(1);
    for (int i = 0; i < 10; i++) commit(32'(4 * i), 1'b1);
    idle();
    status("t2_done", 1, 2'd3, 5'd4, 1'b1, 1'b1);

    // 5: backpressure on the wrapped contents, ready pattern 1,0,0,1,0,0...
    exp5 = '{32'h18, 32'h1C, 32'h20, 32'h24};
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk("t5_vld", 32'(rd_valid_w[1]), 32'(idx < 4));
      chk("t5_cnt", 32'(count_w[1]), 32'(4 - idx));
      if (idx < 4) chk("t5_pc", rd_pc_w[1], exp5[idx]);
      r = (c % 3 == 0);
      rd_ready = r;
      if (r && idx < 4) idx++;
    end
    @(negedge clk); rd_ready = 1'b0;

    // 3: no-wrap drops when full, post counter still runs on dropped commits
    trig_pc = 32'h14;
    do_arm(2);
    for (int i = 0; i < 8; i++) begin
      commit(32'(4 * i), 1'b1);
      if (i == 7) chk("t3_not_done", 32'(state_w[2]), 32'd2);
    end
    idle();
    status("t3_done", 2, 2'd3, 5'd4, 1'b1, 1'b1);
    drain("t3_rd", 2, 32'h0, 4);

    // 4: masked trigger, invalid commit ignored, POST_TRIG 0
    trig_pc = 32'h400; trig_mask = 32'hFFFF_FF00;
    do_arm(3);
    commit(32'h404, 1'b0);
    commit(32'h3FC, 1'b1);
    status("t4_invalid", 3, 2'd1, 5'd0, 1'b0, 1'b0);
    commit(32'h480, 1'b1);
    idle();
    status("t4_done", 3, 2'd3, 5'd2, 1'b1, 1'b0);
    chk("t4_pc0", rd_pc_w[3], 32'h3FC);

    // 6: reset during POST, then a clean capture
    trig_pc = 32'h10; trig_mask = 32'hFFFF_FFFF;
    do_arm(0);
    for (int i = 0; i < 5; i++) commit(32'(4 * i), 1'b1);
    idle();
    status("t6_post", 0, 2'd2, 5'd5, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    status("t6_rst", 0, 2'd0, 5'd0, 1'b0, 1'b0);
    chk("t6_rst_vld", 32'(rd_valid_w[0]), 32'd0);
    do_arm(0);
    for (int i = 0; i < 7; i++) commit(32'(4 * i), 1'b1);
    idle();
    status("t6_done", 0, 2'd3, 5'd7, 1'b1, 1'b0);
    chk("t6_pc0", rd_pc_w[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
Synthesizable commit-trace capture buffer for the MIPS core. It generalises the bench's per-cycle $monitor printout into hardware. It records retired-instruction records (pc, instruction, writeback) into a DEPTH-entry circular store, and supports a masked PC trigger and post-trigger capture. After capture, a valid/ready port streams records out oldest-first to a bench or debug host.

Parameters:
DEPTH, 16, number of trace entries; power of two, >= 4
DATA_W, 32, width of pc, instruction and data_result fields
POST_TRIG, 8, commits captured after the triggering commit; range 0..DEPTH-1
WRAP, 1, 1 = pre-trigger capture overwrites the oldest entry when full; 0 = capture stops when full

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
arm  in  1  single-cycle pulse that starts a capture
trig_pc  in  DATA_W  trigger PC value
trig_mask  in  DATA_W  1 = bit is compared
commit_valid  in  1  pc/instruction/writeback fields valid this cycle
pc  in  DATA_W  committed pc
instruction  in  DATA_W  committed instruction
reg_write_en  in  1  commit writes the register file
write_to_register  in  5  destination register
data_result  in  DATA_W  writeback value
mem_write_en  in  1  commit stores to memory
rd_valid  out  1  record available
rd_ready  in  1  consumer accepts the record
rd_pc, rd_instruction, rd_data  out  DATA_W  record fields
rd_reg  out  5  record destination register
rd_flags  out  2  {mem_write_en, reg_write_en}
state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
count  out  clog2(DEPTH)+1  stored entries
triggered  out  1  trigger seen (sticky until arm/reset)
overflow  out  1  entry lost or overwritten (sticky until arm/reset)

Behaviour:
- Reset (synchronous, takes effect at the edge where reset=1):
  - state=IDLE; wr_ptr, rd_ptr, post counter, count = 0; triggered = 0; overflow = 0.
  - All rd_* outputs are 0. Storage array is not reset.
  - Reset asserted mid-operation aborts capture or readout the same way.
- IDLE: arm=1 -> ARMED next cycle. On that edge, pointers, count, triggered and overflow are cleared. A commit in the arm cycle is not captured.
- Capture (ARMED, POST), per cycle with commit_valid=1:
  - Not full: write the record at wr_ptr; wr_ptr++ mod DEPTH; count++.
  - Full, WRAP=1: overwrite the entry at wr_ptr (the oldest); wr_ptr++ and rd_ptr++; count holds; overflow=1.
  - Full, WRAP=0: record dropped; overflow=1.
  - commit_valid=0: nothing written, no trigger, no post decrement.
- Trigger, in ARMED only: commit_valid && (((pc ^ trig_pc) & trig_mask) == 0).
  - The triggering commit is captured under the rules above.
  - triggered=1; post counter = POST_TRIG.
  - Next state: DONE if POST_TRIG==0, otherwise POST.
  - trig_mask=0 triggers on the first valid commit.
- POST: every valid commit (captured or dropped) decrements the post counter. The commit that takes it to 0 moves the block to DONE. Triggers are ignored in POST.
- arm in ARMED or POST is ignored.
- DONE, no capture:
  - rd_valid = (count != 0).
  - rd_* fields reflect storage at rd_ptr combinationally and are stable while rd_valid && !rd_ready.
  - Transfer when rd_valid && rd_ready: rd_ptr++ mod DEPTH, count--.
  - rd_valid=0 outside DONE, and rd_* are then 0.
- arm in DONE discards unread entries -> ARMED, with the same clearing as from IDLE. If arm coincides with a transfer, arm wins.
- Latency: a commit at edge N is visible in count after edge N. Trigger-to-DONE takes exactly POST_TRIG valid commits.

Test Plan:
1. DEPTH=16, POST_TRIG=2, trig_pc=0x10, mask=0xFFFFFFFF; arm, then 7 commits pc=0x00..0x18 step 4 -> state=DONE after the 0x18 commit, count=7, triggered=1, overflow=0. Readout with rd_ready=1 yields pc 0x00..0x18 in order, then rd_valid=0.
2. WRAP=1, DEPTH=4, POST_TRIG=1, trig_pc=0x20; 10 commits pc=0x00..0x24 -> count=4; readout 0x18, 0x1C, 0x20, 0x24; overflow=1.
3. WRAP=0, DEPTH=4, POST_TRIG=2, trig_pc=0x14; commits 0x00..0x1C -> stored entries 0x00..0x0C, overflow=1, DONE after the 0x1C commit.
4. trig_pc=0x400, mask=0xFFFFFF00; commit_valid=0 with pc=0x404 causes no trigger and no capture. Valid commits 0x3FC, 0x480 -> trigger on 0x480, count=2 (POST_TRIG=0).
5. Readout backpressure with rd_ready toggling 1,0,0,1,... -> fields hold while stalled; each of N entries delivered exactly once, in order; count decrements only on transfer.
6. reset=1 for one cycle during POST with count=5 -> next cycle state=IDLE, count=0, triggered=0, overflow=0, rd_valid=0. A subsequent arm starts a clean capture.
